// File: rtl/rgb_to_raw_ctrl_if.sv
// Config handshake between the register/CPU-side logic and rgb_to_raw_ctrl.
// The CPU side is the master and the conversion controller is the slave.
interface rgb_to_raw_ctrl_if;
  logic       CFG_VALID;
  logic       CFG_READY;
  logic [1:0] CFG_MODE;
  logic       CFG_PHASE;

  modport master (output CFG_VALID, output CFG_MODE, output CFG_PHASE, input CFG_READY);
  modport slave  (input CFG_VALID, input CFG_MODE, input CFG_PHASE, output CFG_READY);
endinterface

// File: rtl/rgb_to_raw_ctrl.sv
// Frame-synchronous mode/phase controller for the RGB/YUV-to-RAW datapath.
// Applies config only at VS, generates row parity, and measures frame/line/pixel counts.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready for a config handshake
// ST_WAIT  | config held in shadow, waiting for VS rise or timer expiry
// ST_APPLY | one cycle: shadow loads into the live mode/phase outputs
module rgb_to_raw_ctrl #(
  parameter int C_PORT_NUM       = 4,
  parameter int C_CNT_W          = 16,
  parameter int C_TIMEOUT_CYCLES = 2**22
) (
  input  logic               VID_CLK,
  input  logic               VID_RSTN,
  input  logic               S_VS,
  input  logic               S_HS,
  input  logic               S_DE,
  rgb_to_raw_ctrl_if.slave   cfg,
  output logic [1:0]         TRANSFER_MODE,
  output logic               ROW_FLIP,
  output logic               MODE_APPLIED,
  output logic               TIMEOUT,
  output logic [15:0]        FRAME_CNT,
  output logic [C_CNT_W-1:0] LINE_CNT,
  output logic [C_CNT_W-1:0] PIX_CNT
);

  localparam int TMR_W = (C_TIMEOUT_CYCLES > 2) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  // Down-counter reaches zero on the cycle the up-count would hit C_TIMEOUT_CYCLES-1
  localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(C_TIMEOUT_CYCLES - 2);
  localparam logic [C_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [C_CNT_W-1:0] PIX_INC  = C_CNT_W'(C_PORT_NUM);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_APPLY} state_t;

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [1:0]         shd_mode;
  logic               shd_phase;
  logic               phase;
  logic               has_de;
  logic               vs_d, hs_d, de_d;
  logic               vs_rise, hs_rise, de_rise, de_fall;
  logic [C_CNT_W-1:0] line_acc;
  logic [C_CNT_W-1:0] pix_acc;

  assign vs_rise = S_VS & ~vs_d;
  assign hs_rise = S_HS & ~hs_d;
  assign de_rise = S_DE & ~de_d;
  assign de_fall = ~S_DE & de_d;

  always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
    if (!VID_RSTN) begin
      state         <= ST_IDLE;
      tmr           <= '0;
      shd_mode      <= 2'd0;
      shd_phase     <= 1'b0;
      phase         <= 1'b0;
      has_de        <= 1'b0;
      TRANSFER_MODE <= 2'd0;
      ROW_FLIP      <= 1'b0;
      MODE_APPLIED  <= 1'b0;
      TIMEOUT       <= 1'b0;
      cfg.CFG_READY <= 1'b1;
    end else begin
      MODE_APPLIED <= 1'b0;

      if (vs_rise)   has_de <= 1'b0;
      else if (S_DE) has_de <= 1'b1;

      if (state == ST_APPLY)       ROW_FLIP <= shd_phase;
      else if (vs_rise)            ROW_FLIP <= phase;
      else if (hs_rise && has_de)  ROW_FLIP <= ~ROW_FLIP;

      case (state)
        ST_IDLE: begin
          if (cfg.CFG_VALID && cfg.CFG_READY) begin
            shd_mode      <= (cfg.CFG_MODE == 2'd3) ? 2'd0 : cfg.CFG_MODE;
            shd_phase     <= cfg.CFG_PHASE;
            tmr           <= TMR_LOAD;
            cfg.CFG_READY <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (vs_rise) begin
            TIMEOUT <= 1'b0;
            state   <= ST_APPLY;
          end else if (tmr == '0) begin
            TIMEOUT <= 1'b1;
            state   <= ST_APPLY;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_APPLY: begin
          TRANSFER_MODE <= shd_mode;
          phase         <= shd_phase;
          MODE_APPLIED  <= 1'b1;
          cfg.CFG_READY <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
    if (!VID_RSTN) begin
      vs_d      <= 1'b0;
      hs_d      <= 1'b0;
      de_d      <= 1'b0;
      FRAME_CNT <= '0;
      line_acc  <= '0;
      LINE_CNT  <= '0;
      pix_acc   <= '0;
      PIX_CNT   <= '0;
    end else begin
      vs_d <= S_VS;
      hs_d <= S_HS;
      de_d <= S_DE;

      if (vs_rise) FRAME_CNT <= FRAME_CNT + 16'd1;

      // A line starting on the VS edge belongs to the new frame
      if (vs_rise) begin
        LINE_CNT <= line_acc;
        line_acc <= C_CNT_W'(de_rise);
      end else if (de_rise && line_acc != CNT_MAX) begin
        line_acc <= line_acc + 1'b1;
      end

      if (de_fall) begin
        PIX_CNT <= pix_acc;
        pix_acc <= '0;
      end else if (S_DE) begin
        pix_acc <= (pix_acc > CNT_MAX - PIX_INC) ? CNT_MAX : pix_acc + PIX_INC;
      end
    end
  end

endmodule
